// File: rtl/alu_rs_pkg.sv
// Shared widths, ALU opcodes and the reservation-station entry type for alu_rs.
// Also holds the operand wakeup helper used both at dispatch and by resident entries.
package alu_rs_pkg;

  localparam int XLEN           = 32;
  localparam int ALU_OP_WIDTH   = 4;
  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT = 4'd7;

  typedef struct packed {
    logic                      busy;
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [XLEN-1:0]           vj;
    logic [XLEN-1:0]           vk;
    logic                      qj_pend;
    logic                      qk_pend;
    logic [ROB_SIZE_WIDTH-1:0] qj;
    logic [ROB_SIZE_WIDTH-1:0] qk;
    logic [ROB_SIZE_WIDTH-1:0] id;
  } rs_entry_t;

  // Returns {pend, value} after snooping both CDB ports; the ALU port wins a double match.
  function automatic logic [XLEN:0] wakeOperand(
    input logic                      pend,
    input logic [ROB_SIZE_WIDTH-1:0] tag,
    input logic [XLEN-1:0]           val,
    input logic                      aluReady,
    input logic [ROB_SIZE_WIDTH-1:0] aluId,
    input logic [XLEN-1:0]           aluRes,
    input logic                      lsbReady,
    input logic [ROB_SIZE_WIDTH-1:0] lsbId,
    input logic [XLEN-1:0]           lsbRes
  );
    if (pend && aluReady && (tag == aluId)) return {1'b0, aluRes};
    if (pend && lsbReady && (tag == lsbId)) return {1'b0, lsbRes};
    return {pend, val};
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder: found_o when any request is set, idx_o is the lowest one.
module rs_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  assign found_o = |req_i;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive, issues one per cycle.
// Optional ALU_RS_BYPASS_EN lets a fully-ready dispatch issue at the same edge when nothing is queued.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE       = 8,
  parameter int RS_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      dec_valid,
  input  logic [ALU_OP_WIDTH-1:0]   dec_op,
  input  logic [XLEN-1:0]           dec_vj,
  input  logic [XLEN-1:0]           dec_vk,
  input  logic                      dec_qj_pend,
  input  logic                      dec_qk_pend,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_qj,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_qk,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_id,
  input  logic                      alu_ready,
  input  logic [XLEN-1:0]           alu_res,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
  input  logic                      lsb_ready,
  input  logic [XLEN-1:0]           lsb_res,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
  output logic                      rs_full,
  output logic                      rs_ready,
  output logic [ALU_OP_WIDTH-1:0]   rs_op,
  output logic [XLEN-1:0]           rs_val1,
  output logic [XLEN-1:0]           rs_val2,
  output logic [ROB_SIZE_WIDTH-1:0] rs_id
);

  rs_entry_t entries_q [RS_SIZE];
  rs_entry_t entries_d [RS_SIZE];

  logic                      rsReady_q, rsReady_d;
  logic [ALU_OP_WIDTH-1:0]   rsOp_q, rsOp_d;
  logic [XLEN-1:0]           rsVal1_q, rsVal1_d;
  logic [XLEN-1:0]           rsVal2_q, rsVal2_d;
  logic [ROB_SIZE_WIDTH-1:0] rsId_q, rsId_d;

  logic [RS_SIZE-1:0]       busyVec, readyVec;
  logic                     freeFound, issueFound;
  logic [RS_SIZE_WIDTH-1:0] freeIdx, issueIdx;
  logic                     dispatchEn, bypassEn;
  logic [XLEN:0]            fwdJ, fwdK;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busyVec[i]  = entries_q[i].busy;
      readyVec[i] = entries_q[i].busy && !entries_q[i].qj_pend && !entries_q[i].qk_pend;
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) uFreeEnc (
    .req_i  (~busyVec),
    .found_o(freeFound),
    .idx_o  (freeIdx)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) uIssueEnc (
    .req_i  (readyVec),
    .found_o(issueFound),
    .idx_o  (issueIdx)
  );

  assign rs_full    = ~freeFound;
  assign dispatchEn = dec_valid && !rs_full && !flush;

  assign fwdJ = wakeOperand(dec_qj_pend, dec_qj, dec_vj, alu_ready, alu_id, alu_res,
                            lsb_ready, lsb_id, lsb_res);
  assign fwdK = wakeOperand(dec_qk_pend, dec_qk, dec_vk, alu_ready, alu_id, alu_res,
                            lsb_ready, lsb_id, lsb_res);

`ifdef ALU_RS_BYPASS_EN
  assign bypassEn = dispatchEn && !issueFound && !fwdJ[XLEN] && !fwdK[XLEN];
`else
  assign bypassEn = 1'b0;
`endif

  // Free and issue slots come from registered busy bits, so an entry issued this cycle
  // cannot be reallocated until the next one.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].busy) begin
        {entries_d[i].qj_pend, entries_d[i].vj} =
          wakeOperand(entries_q[i].qj_pend, entries_q[i].qj, entries_q[i].vj,
                      alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res);
        {entries_d[i].qk_pend, entries_d[i].vk} =
          wakeOperand(entries_q[i].qk_pend, entries_q[i].qk, entries_q[i].vk,
                      alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res);
      end
    end
    if (issueFound) entries_d[issueIdx].busy = 1'b0;
    if (dispatchEn && !bypassEn) begin
      entries_d[freeIdx].busy    = 1'b1;
      entries_d[freeIdx].op      = dec_op;
      entries_d[freeIdx].vj      = fwdJ[XLEN-1:0];
      entries_d[freeIdx].vk      = fwdK[XLEN-1:0];
      entries_d[freeIdx].qj_pend = fwdJ[XLEN];
      entries_d[freeIdx].qk_pend = fwdK[XLEN];
      entries_d[freeIdx].qj      = dec_qj;
      entries_d[freeIdx].qk      = dec_qk;
      entries_d[freeIdx].id      = dec_id;
    end
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) entries_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    rsReady_d = 1'b0;
    rsOp_d    = '0;
    rsVal1_d  = '0;
    rsVal2_d  = '0;
    rsId_d    = '0;
    if (flush) begin
      rsReady_d = 1'b0;
    end else if (issueFound) begin
      rsReady_d = 1'b1;
      rsOp_d    = entries_q[issueIdx].op;
      rsVal1_d  = entries_q[issueIdx].vj;
      rsVal2_d  = entries_q[issueIdx].vk;
      rsId_d    = entries_q[issueIdx].id;
    end else if (bypassEn) begin
      rsReady_d = 1'b1;
      rsOp_d    = dec_op;
      rsVal1_d  = fwdJ[XLEN-1:0];
      rsVal2_d  = fwdK[XLEN-1:0];
      rsId_d    = dec_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
      rsReady_q <= 1'b0;
      rsOp_q    <= '0;
      rsVal1_q  <= '0;
      rsVal2_q  <= '0;
      rsId_q    <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= entries_d[i];
      rsReady_q <= rsReady_d;
      rsOp_q    <= rsOp_d;
      rsVal1_q  <= rsVal1_d;
      rsVal2_q  <= rsVal2_d;
      rsId_q    <= rsId_d;
    end
  end

  assign rs_ready = rsReady_q;
  assign rs_op    = rsOp_q;
  assign rs_val1  = rsVal1_q;
  assign rs_val2  = rsVal2_q;
  assign rs_id    = rsId_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: vector table plus hand-written wakeup, full, flush and reset sequences.
// Expected issues are queued at dispatch and popped whenever rs_ready is seen.
module tb_alu_rs;
  import alu_rs_pkg::*;

`ifdef ALU_RS_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      flush;
  logic                      dec_valid;
  logic [ALU_OP_WIDTH-1:0]   dec_op;
  logic [XLEN-1:0]           dec_vj, dec_vk;
  logic                      dec_qj_pend, dec_qk_pend;
  logic [ROB_SIZE_WIDTH-1:0] dec_qj, dec_qk, dec_id;
  logic                      alu_ready, lsb_ready;
  logic [XLEN-1:0]           alu_res, lsb_res;
  logic [ROB_SIZE_WIDTH-1:0] alu_id, lsb_id;
  logic                      rs_full, rs_ready;
  logic [ALU_OP_WIDTH-1:0]   rs_op;
  logic [XLEN-1:0]           rs_val1, rs_val2;
  logic [ROB_SIZE_WIDTH-1:0] rs_id;

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_vj(dec_vj), .dec_vk(dec_vk),
    .dec_qj_pend(dec_qj_pend), .dec_qk_pend(dec_qk_pend),
    .dec_qj(dec_qj), .dec_qk(dec_qk), .dec_id(dec_id),
    .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id),
    .lsb_ready(lsb_ready), .lsb_res(lsb_res), .lsb_id(lsb_id),
    .rs_full(rs_full), .rs_ready(rs_ready), .rs_op(rs_op),
    .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [XLEN-1:0]           v1;
    logic [XLEN-1:0]           v2;
    logic [ROB_SIZE_WIDTH-1:0] id;
  } issueT;

  typedef struct {
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [XLEN-1:0]           vj, vk;
    logic                      qjPend, qkPend;
    logic [ROB_SIZE_WIDTH-1:0] qj, qk, id;
    logic                      aluV;
    logic [ROB_SIZE_WIDTH-1:0] aluTag;
    logic [XLEN-1:0]           aluVal;
    logic                      lsbV;
    logic [ROB_SIZE_WIDTH-1:0] lsbTag;
    logic [XLEN-1:0]           lsbVal;
    logic [XLEN-1:0]           expV1, expV2;
  } vecT;

  issueT expQ[$];
  vecT   vecs[6];
  int    checkCount = 0;
  int    passCount = 0;
  int    issuedCount = 0;
  int    fullViolations = 0;
  logic  allowFullDispatch = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idleInputs();
    flush = 1'b0; dec_valid = 1'b0; dec_op = '0; dec_vj = '0; dec_vk = '0;
    dec_qj_pend = 1'b0; dec_qk_pend = 1'b0; dec_qj = '0; dec_qk = '0; dec_id = '0;
    alu_ready = 1'b0; alu_res = '0; alu_id = '0;
    lsb_ready = 1'b0; lsb_res = '0; lsb_id = '0;
  endtask

  // Advance one edge and score any issue against the front of the expectation queue.
  task automatic tick();
    issueT e;
    @(posedge clk);
    #1;
    if (rs_ready === 1'b1) begin
      issuedCount++;
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected issue: got rs_id=%0d, expected no issue", rs_id);
      end else begin
        e = expQ.pop_front();
        checkOutput("issue op", 32'(rs_op), 32'(e.op));
        checkOutput("issue val1", rs_val1, e.v1);
        checkOutput("issue val2", rs_val2, e.v2);
        checkOutput("issue id", 32'(rs_id), 32'(e.id));
      end
    end
  endtask

  task automatic driveDispatch(input logic [ALU_OP_WIDTH-1:0] op, input logic [XLEN-1:0] vj,
                               input logic [XLEN-1:0] vk, input logic qjP,
                               input logic [ROB_SIZE_WIDTH-1:0] qj, input logic qkP,
                               input logic [ROB_SIZE_WIDTH-1:0] qk,
                               input logic [ROB_SIZE_WIDTH-1:0] id);
    dec_valid = 1'b1; dec_op = op; dec_vj = vj; dec_vk = vk;
    dec_qj_pend = qjP; dec_qj = qj; dec_qk_pend = qkP; dec_qk = qk; dec_id = id;
  endtask

  task automatic applyStimulus(input vecT t);
    driveDispatch(t.op, t.vj, t.vk, t.qjPend, t.qj, t.qkPend, t.qk, t.id);
    alu_ready = t.aluV; alu_id = t.aluTag; alu_res = t.aluVal;
    lsb_ready = t.lsbV; lsb_id = t.lsbTag; lsb_res = t.lsbVal;
  endtask

  task automatic runVector(input vecT t);
    int edges;
    int start;
    start = issuedCount;
    applyStimulus(t);
    expQ.push_back('{op: t.op, v1: t.expV1, v2: t.expV2, id: t.id});
    edges = 0;
    do begin
      tick();
      idleInputs();
      edges++;
    end while (issuedCount == start && edges < 6);
    checkOutput("vector latency", 32'(edges), 32'(LAT));
    if (issuedCount == start) expQ.delete();
    tick();
    checkOutput("vector pulse width", 32'(rs_ready), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && dec_valid && rs_full && !allowFullDispatch) begin
      fullViolations++;
      $display("[TB] FAIL dispatch while full: got dec_valid=1 with rs_full=1, expected no dispatch");
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{ALU_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd7};
    vecs[1] = '{ALU_ADD, 32'h11, 32'd0, 1'b0, 1'b1, 4'd0, 4'd6, 4'd5,
                1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'h11, 32'hFFFF_FFFF};
    vecs[2] = '{ALU_SUB, 32'd0, 32'h22, 1'b1, 1'b0, 4'd7, 4'd0, 4'd8,
                1'b1, 4'd7, 32'h1234, 1'b0, 4'd0, 32'd0, 32'h1234, 32'h22};
    vecs[3] = '{ALU_OR, 32'd0, 32'd0, 1'b1, 1'b1, 4'd8, 4'd10, 4'd2,
                1'b1, 4'd8, 32'hAA, 1'b1, 4'd10, 32'hBB, 32'hAA, 32'hBB};
    vecs[4] = '{ALU_SLT, 32'h77, 32'h5, 1'b0, 1'b0, 4'd3, 4'd0, 4'd9,
                1'b1, 4'd3, 32'h99, 1'b0, 4'd0, 32'd0, 32'h77, 32'h5};
    vecs[5] = '{ALU_AND, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15,
                1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};

    idleInputs();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rs_ready", 32'(rs_ready), 32'd0);
    checkOutput("reset rs_full", 32'(rs_full), 32'd0);
    checkOutput("reset rs_id", 32'(rs_id), 32'd0);
    checkOutput("reset rs_val1", rs_val1, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) runVector(vecs[v]);

    // Wakeup from both CDB ports on resident entries
    driveDispatch(ALU_SUB, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    expQ.push_back('{op: ALU_SUB, v1: 32'd10, v2: 32'd1, id: 4'd4});
    tick();
    driveDispatch(ALU_OR, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd11, 4'd6);
    expQ.push_back('{op: ALU_OR, v1: 32'd3, v2: 32'h55, id: 4'd6});
    tick();
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("pending hold", 32'(rs_ready), 32'd0);
    end
    alu_ready = 1'b1; alu_id = 4'd2; alu_res = 32'd10;
    lsb_ready = 1'b1; lsb_id = 4'd11; lsb_res = 32'h55;
    tick();
    idleInputs();
    checkOutput("wake edge no issue", 32'(rs_ready), 32'd0);
    tick();
    checkOutput("wake issue ready", 32'(rs_ready), 32'd1);
    checkOutput("wake issue first id", 32'(rs_id), 32'd4);
    tick();
    checkOutput("wake issue second id", 32'(rs_id), 32'd6);
    tick();
    checkOutput("wake drained", 32'(rs_ready), 32'd0);

    // Fill all entries on tag 9, try one more, then drain in index order
    for (int i = 0; i < 8; i++) begin
      driveDispatch(ALU_ADD, 32'd0, 32'(i * 3), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
      expQ.push_back('{op: ALU_ADD, v1: 32'hCAFE, v2: 32'(i * 3), id: 4'(i)});
      tick();
      checkOutput("fill rs_full", 32'(rs_full), (i == 7) ? 32'd1 : 32'd0);
    end
    allowFullDispatch = 1'b1;
    driveDispatch(ALU_ADD, 32'd0, 32'h99, 1'b1, 4'd9, 1'b0, 4'd0, 4'd13);
    tick();
    idleInputs();
    allowFullDispatch = 1'b0;
    checkOutput("full held", 32'(rs_full), 32'd1);
    alu_ready = 1'b1; alu_id = 4'd9; alu_res = 32'hCAFE;
    tick();
    idleInputs();
    checkOutput("full wake edge", 32'(rs_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("drain order id", 32'(rs_id), 32'(i));
      if (i == 0) checkOutput("full falls after first issue", 32'(rs_full), 32'd0);
    end
    tick();
    checkOutput("ignored dispatch absent", 32'(rs_ready), 32'd0);

    // Flush with a woken entry and a concurrent dispatch
    for (int i = 0; i < 4; i++) begin
      driveDispatch(ALU_AND, 32'(i), 32'(i), 1'b1, 4'd12, 1'b0, 4'd0, 4'(i));
      tick();
    end
    idleInputs();
    alu_ready = 1'b1; alu_id = 4'd12; alu_res = 32'h77;
    tick();
    idleInputs();
    driveDispatch(ALU_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    flush = 1'b1;
    tick();
    idleInputs();
    checkOutput("flush rs_ready", 32'(rs_ready), 32'd0);
    checkOutput("flush rs_full", 32'(rs_full), 32'd0);
    checkOutput("flush rs_id", 32'(rs_id), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post-flush idle", 32'(rs_ready), 32'd0);
    end

    // Async reset while an issue is on the outputs
    driveDispatch(ALU_XOR, 32'hF0, 32'h0F, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    expQ.push_back('{op: ALU_XOR, v1: 32'hF0, v2: 32'h0F, id: 4'd1});
    tick();
`ifdef ALU_RS_BYPASS_EN
    checkOutput("bypass one-edge issue", 32'(rs_ready), 32'd1);
`endif
    driveDispatch(ALU_ADD, 32'd1, 32'd1, 1'b1, 4'd14, 1'b0, 4'd0, 4'd2);
    tick();
    idleInputs();
`ifdef ALU_RS_BYPASS_EN
    checkOutput("bypass no residue", 32'(rs_ready), 32'd0);
`else
    checkOutput("mid-issue before reset", 32'(rs_ready), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset rs_ready", 32'(rs_ready), 32'd0);
    checkOutput("async reset rs_full", 32'(rs_full), 32'd0);
    checkOutput("async reset rs_val1", rs_val1, 32'd0);
    tick();
    rst_n = 1'b1;
    alu_ready = 1'b1; alu_id = 4'd14; alu_res = 32'h5;
    tick();
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post-reset idle", 32'(rs_ready), 32'd0);
    end

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount + fullViolations);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the ALU in the Tomasulo core.
- Accepts decoded ALU ops from dispatch and holds them until both operands are available.
- Wakes operands from the CDB (ALU and LSB broadcasts).
- Issues one ready instruction per cycle on the rs_* interface that the ALU samples.

Parameters:
- RS_SIZE, 8, number of entries.
- RS_SIZE_WIDTH, 3, log2(RS_SIZE).
- XLEN, `XLEN (32), operand width.
- ALU_OP_WIDTH, `ALU_OP_WIDTH, ALU opcode width.
- ROB_SIZE_WIDTH, `ROB_SIZE_WIDTH, ROB tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- flush  in  1  sync mispredict flush.
- dec_valid  in  1  dispatch request.
- dec_op  in  ALU_OP_WIDTH  opcode.
- dec_vj, dec_vk  in  XLEN  operand values (valid when not pending).
- dec_qj_pend, dec_qk_pend  in  1  operand waits on a tag.
- dec_qj, dec_qk  in  ROB_SIZE_WIDTH  producer tags.
- dec_id  in  ROB_SIZE_WIDTH  ROB id of the instruction.
- alu_ready  in  1  ALU CDB broadcast valid.
- alu_res  in  XLEN  ALU broadcast value.
- alu_id  in  ROB_SIZE_WIDTH  ALU broadcast tag.
- lsb_ready  in  1  LSB CDB broadcast valid.
- lsb_res  in  XLEN  LSB broadcast value.
- lsb_id  in  ROB_SIZE_WIDTH  LSB broadcast tag.
- rs_full  out  1  no free entry.
- rs_ready  out  1  issue valid to ALU.
- rs_op  out  ALU_OP_WIDTH  issued opcode.
- rs_val1, rs_val2  out  XLEN  issued operands.
- rs_id  out  ROB_SIZE_WIDTH  issued ROB id.

Behaviour:
- Reset: every entry is not busy; rs_ready=0; rs_op, rs_val1, rs_val2, rs_id=0; rs_full=0. Reset asserted mid-operation drops all entries immediately.
- Entry state: busy, op, vj, vk, qj_pend, qk_pend, qj, qk, id.
- rs_full is combinational: all busy bits set, from registered state only.
- Dispatch: if dec_valid && !rs_full && !flush, write the lowest-index non-busy entry at the clock edge.
  - dec_valid while rs_full is ignored; the dispatcher must not do this, and the bench asserts it never happens.
- Same-cycle forwarding at dispatch: if an operand is pending and a valid CDB broadcast tag matches it, store the broadcast value and clear the pend bit.
  - If alu and lsb both match, the ALU value wins; equal tags on both are illegal.
- Wakeup: every busy entry with a pend bit set compares qj/qk against alu_id (when alu_ready) and lsb_id (when lsb_ready). On a match, capture the value and clear the pend bit at the edge.
- Issue select (from registered state): the lowest-index busy entry with qj_pend=0 and qk_pend=0.
  - At the edge: rs_ready<=1, rs_op/rs_val1/rs_val2/rs_id <= entry fields, entry busy<=0.
  - If no candidate: rs_ready<=0 and data outputs <=0.
- Latency: dispatch with both operands ready at edge t -> eligible at t+1 -> rs_ready high after edge t+1 -> ALU result after t+2.
  - Woken at edge t -> issued at edge t+1 at the earliest.
- Simultaneous events:
  - An entry freed by issue is not reusable by a dispatch in the same cycle.
  - Dispatch and issue in the same cycle are independent.
  - Wakeup of an entry being issued in the same cycle is irrelevant, because it was already ready.
- Flush (synchronous, priority over dispatch/issue/wakeup): clear all busy bits and drive rs_ready<=0 with data outputs <=0.
- No backpressure from the ALU: it accepts one op every cycle.

Optional Feature:
- Macro: ALU_RS_BYPASS_EN.
- Defined:
  - A dispatch with both operands ready (after forwarding), arriving when no stored entry is a candidate, issues directly at the same edge and allocates no entry.
  - Gives 1-cycle dispatch-to-rs_ready latency.
  - rs_full still gates dec_valid.
- Undefined: every dispatch allocates an entry (2-edge minimum latency).

Decomposition:
- The shared global_params.v carries `XLEN, `ALU_OP_WIDTH, `ALU_* opcodes, `ROB_SIZE_WIDTH, and new `RS_SIZE / `RS_SIZE_WIDTH.
- One sub-module: rs_prio_enc, a parameterised lowest-index-first encoder with outputs found and idx. It is instantiated twice: free-entry select and ready-entry select.

Test Plan:
- Reset release, then dispatch ADD vj=5 vk=7 id=3 with no pend bits -> rs_ready=1, rs_op=ALU_ADD, rs_val1=5, rs_val2=7, rs_id=3 exactly one cycle (two edges after dispatch without bypass).
- Dispatch SUB id=4 with qj_pend, qj=2, vk=1. Hold for 3 cycles -> no issue. Then alu_ready, alu_id=2, alu_res=10 -> next edge issues rs_val1=10, rs_val2=1, rs_id=4.
- Dispatch with qk_pend, qk=6 in the same cycle that lsb_ready, lsb_id=6, lsb_res=0xFFFF_FFFF -> entry stores vk=0xFFFF_FFFF and issues as in the no-wait case.
- Fill 8 entries all pending on tag 9 -> rs_full=1, and a further dec_valid is ignored. Broadcast alu_id=9 -> 8 consecutive issues in index order 0..7; rs_full falls after the first issue.
- 4 entries resident, flush asserted together with dec_valid -> next cycle rs_ready=0, rs_full=0, and no issue ever occurs for the flushed entries. Assert rst_n=0 mid-issue -> rs_ready=0 immediately.
- ALU_RS_BYPASS_EN defined: dispatch XOR 0xF0/0x0F id=1 into an empty station -> rs_ready=1, rs_val1=0xF0, rs_val2=0x0F after one edge, and no entry stays busy.
